// File: rtl/display_scan_controller_if.sv
// Frame-load handshake and multiplexed 7-segment drive signals of the display scan controller.
interface display_scan_controller_if;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  dp_sel;
  logic        blank_lz;
  logic [3:0]  num_out;
  logic        dp_n;
  logic [3:0]  digit_en_n;
  logic        err;

  modport master (
    output load_valid, load_data, dp_sel, blank_lz,
    input  load_ready, num_out, dp_n, digit_en_n, err
  );

  modport slave (
    input  load_valid, load_data, dp_sel, blank_lz,
    output load_ready, num_out, dp_n, digit_en_n, err
  );
endinterface

// File: rtl/display_scan_controller.sv
// Four-digit multiplexed 7-segment scan controller: a double-buffered frame is copied to the
// active set at frame boundaries only, with leading-zero blanking and a sticky non-BCD flag.
module display_scan_controller #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                      clk,
  input  logic                      reset,
  display_scan_controller_if.slave  bus
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        blz;
  } frame_t;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state_q;
  frame_t        pend_q, act_q, in_frame;
  logic          pend_full_q, pend_full_d;
  logic          ready_q;
  logic          err_q;
  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;
  logic [3:0]    num_q;
  logic          dp_n_q;
  logic [3:0]    en_n_q;
  logic          bad_nib;
  logic [3:0]    nib;
  logic [3:0]    blank;
  logic          accept;
  logic          tick;
  logic          copy;

  // Non-BCD nibbles are stored as zero and flagged.
  always_comb begin
    in_frame      = '0;
    in_frame.dp   = bus.dp_sel;
    in_frame.blz  = bus.blank_lz;
    bad_nib       = 1'b0;
    nib           = 4'd0;
    for (int i = 0; i < 4; i++) begin
      nib = bus.load_data[4*i +: 4];
      if (nib > 4'd9) begin
        bad_nib = 1'b1;
      end else begin
        in_frame.data[4*i +: 4] = nib;
      end
    end
  end

  // A digit is blanked when it and every digit to its left are zero; digit0 always shows.
  always_comb begin
    blank    = 4'b0000;
    blank[3] = act_q.blz && (act_q.data[15:12] == 4'd0);
    blank[2] = blank[3] && (act_q.data[11:8] == 4'd0);
    blank[1] = blank[2] && (act_q.data[7:4] == 4'd0);
  end

  always_comb begin
    accept      = bus.load_valid && ready_q;
    tick        = (presc_q == PRESC_LAST);
    copy        = pend_full_q && ((state_q == IDLE) ||
                                  (tick && (idx_q == 2'd3)));
    pend_full_d = pend_full_q;
    if (accept) begin
      pend_full_d = 1'b1;
    end else if (copy) begin
      pend_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      act_q       <= '0;
      pend_full_q <= 1'b0;
      ready_q     <= 1'b1;
      err_q       <= 1'b0;
      presc_q     <= '0;
      idx_q       <= 2'd0;
      num_q       <= 4'd0;
      dp_n_q      <= 1'b1;
      en_n_q      <= 4'b1111;
    end else begin
      pend_full_q <= pend_full_d;
      ready_q     <= ~pend_full_d;
      err_q       <= err_q | (accept & bad_nib);
      if (accept) begin
        pend_q <= in_frame;
      end
      if (copy) begin
        act_q <= pend_q;
      end

      unique case (state_q)
        IDLE: begin
          num_q  <= 4'd0;
          dp_n_q <= 1'b1;
          en_n_q <= 4'b1111;
          if (pend_full_q) begin
            state_q <= SCAN;
            idx_q   <= 2'd0;
            presc_q <= '0;
          end
        end
        SCAN: begin
          presc_q <= tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            idx_q <= idx_q + 2'd1;
          end
          // Drive reflects the idx/active values held before this edge.
          if (blank[idx_q]) begin
            num_q  <= 4'd0;
            dp_n_q <= 1'b1;
            en_n_q <= 4'b1111;
          end else begin
            num_q  <= act_q.data[{idx_q, 2'b00} +: 4];
            dp_n_q <= ~act_q.dp[idx_q];
            en_n_q <= ~(4'b0001 << idx_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.load_ready = ready_q;
  assign bus.num_out    = num_q;
  assign bus.dp_n       = dp_n_q;
  assign bus.digit_en_n = en_n_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed self-checking bench for display_scan_controller with REFRESH_DIV=4.
module tb_display_scan_controller;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  display_scan_controller_if bus();

  display_scan_controller #(.REFRESH_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] drive_word();
    return {23'd0, bus.num_out, bus.digit_en_n, bus.dp_n};
  endfunction

  task automatic expect_slot(input string tag, input logic [3:0] num,
                             input logic [3:0] en, input logic dp);
    repeat (4) begin
      step();
      check(tag, drive_word(), {23'd0, num, en, dp});
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.load_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Offers one frame for a single cycle; returns just after the accepting edge.
  task automatic load(input logic [15:0] data, input logic [3:0] dp, input logic blz);
    bus.load_valid = 1'b1;
    bus.load_data  = data;
    bus.dp_sel     = dp;
    bus.blank_lz   = blz;
    step();
    bus.load_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    int          slot;
    logic [1:0]  idx;
    logic        exp_rdy;

    reset = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data  = 16'h0;
    bus.dp_sel     = 4'h0;
    bus.blank_lz   = 1'b0;
    step();
    check("rst_drive", drive_word(), {23'd0, 4'd0, 4'b1111, 1'b1});
    check("rst_ready", 32'(bus.load_ready), 32'd1);
    check("rst_err",   32'(bus.err), 32'd0);
    step();
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step();
      check("idle", {26'd0, bus.digit_en_n, bus.load_ready, bus.err}, {26'd0, 4'b1111, 1'b1, 1'b0});
    end

    // Basic scan of 1234 with the decimal point on digit2.
    load(16'h1234, 4'b0100, 1'b0);
    check("acc_ready", 32'(bus.load_ready), 32'd0);
    step();
    check("enter_scan", drive_word(), {23'd0, 4'd0, 4'b1111, 1'b1});
    check("ready_back", 32'(bus.load_ready), 32'd1);
    repeat (2) begin
      expect_slot("s1234_d0", 4'd4, 4'b1110, 1'b1);
      expect_slot("s1234_d1", 4'd3, 4'b1101, 1'b1);
      expect_slot("s1234_d2", 4'd2, 4'b1011, 1'b0);
      expect_slot("s1234_d3", 4'd1, 4'b0111, 1'b1);
    end

    // Leading-zero blanking.
    do_reset();
    load(16'h0050, 4'b0000, 1'b1);
    step();
    expect_slot("b0050_d0", 4'd0, 4'b1110, 1'b1);
    expect_slot("b0050_d1", 4'd5, 4'b1101, 1'b1);
    expect_slot("b0050_d2", 4'd0, 4'b1111, 1'b1);
    expect_slot("b0050_d3", 4'd0, 4'b1111, 1'b1);
    do_reset();
    load(16'h0000, 4'b0000, 1'b1);
    step();
    expect_slot("b0000_d0", 4'd0, 4'b1110, 1'b1);
    expect_slot("b0000_d1", 4'd0, 4'b1111, 1'b1);
    expect_slot("b0000_d2", 4'd0, 4'b1111, 1'b1);
    expect_slot("b0000_d3", 4'd0, 4'b1111, 1'b1);

    // Mid-frame load held until the frame boundary, then a back-to-back second load.
    do_reset();
    load(16'h1234, 4'b0000, 1'b0);
    step();
    for (int n = 1; n <= 36; n++) begin
      if (n == 5) begin
        bus.load_valid = 1'b1;
        bus.load_data  = 16'h5678;
      end
      if (n == 6)  bus.load_data = 16'h9876;
      if (n == 18) bus.load_valid = 1'b0;
      step();
      slot = (n - 1) / 4;
      idx  = 2'(slot % 4);
      w    = (slot < 4) ? 16'h1234 : (slot < 8) ? 16'h5678 : 16'h9876;
      exp_rdy = (n <= 4) || (n == 16) || (n >= 32);
      check($sformatf("tear_out_%0d", n), drive_word(),
            {23'd0, w[{idx, 2'b00} +: 4], ~(4'b0001 << idx), 1'b1});
      check($sformatf("tear_rdy_%0d", n), 32'(bus.load_ready), 32'(exp_rdy));
    end

    // Non-BCD nibble: stored as zero, sticky err.
    do_reset();
    check("err_pre", 32'(bus.err), 32'd0);
    load(16'h12A4, 4'b0000, 1'b0);
    check("err_set", 32'(bus.err), 32'd1);
    step();
    expect_slot("e12A4_d0", 4'd4, 4'b1110, 1'b1);
    expect_slot("e12A4_d1", 4'd0, 4'b1101, 1'b1);
    expect_slot("e12A4_d2", 4'd2, 4'b1011, 1'b1);
    expect_slot("e12A4_d3", 4'd1, 4'b0111, 1'b1);
    check("err_sticky", 32'(bus.err), 32'd1);
    do_reset();
    check("err_clr", 32'(bus.err), 32'd0);

    // Async reset during the idx=2 slot with a pending frame.
    load(16'h1234, 4'b0100, 1'b0);
    step();
    expect_slot("r_d0", 4'd4, 4'b1110, 1'b1);
    expect_slot("r_d1", 4'd3, 4'b1101, 1'b1);
    bus.load_valid = 1'b1;
    bus.load_data  = 16'h5678;
    step();
    bus.load_valid = 1'b0;
    check("r_pend", 32'(bus.load_ready), 32'd0);
    check("r_d2", drive_word(), {23'd0, 4'd2, 4'b1011, 1'b0});
    step();
    reset = 1'b1;
    #1;
    check("r_async_drive", drive_word(), {23'd0, 4'd0, 4'b1111, 1'b1});
    check("r_async_ready", 32'(bus.load_ready), 32'd1);
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("r_idle", {26'd0, bus.digit_en_n, bus.load_ready, bus.err}, {26'd0, 4'b1111, 1'b1, 1'b0});
    end
    load(16'h0009, 4'b0000, 1'b0);
    step();
    expect_slot("r_new_d0", 4'd9, 4'b1110, 1'b1);
    expect_slot("r_new_d1", 4'd0, 4'b1101, 1'b1);
    expect_slot("r_new_d2", 4'd0, 4'b1011, 1'b1);
    expect_slot("r_new_d3", 4'd0, 4'b0111, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; all state SHALL be clocked on the rising edge of clk.
REQ-002 Parameter: REFRESH_DIV, 50000, clk cycles per digit slot; legal range 2..2^20.
REQ-003 Port: clk  in  1  system clock.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: load_valid  in  1  new display frame offered.
REQ-006 Port: load_ready  out  1  controller can accept a frame.
REQ-007 Port: load_data  in  16  four BCD digits; digit0 (rightmost) = [3:0], digit3 = [15:12].
REQ-008 Port: dp_sel  in  4  decimal-point enable per digit; bit i = digit i; latched with load_data.
REQ-009 Port: blank_lz  in  1  leading-zero blanking enable; latched with load_data.
REQ-010 Port: num_out  out  4  BCD value to the shared 7-segment decoder.
REQ-011 Port: dp_n  out  1  active-low decimal point for the current digit.
REQ-012 Port: digit_en_n  out  4  active-low, one-hot or all-high digit enable.
REQ-013 Port: err  out  1  sticky flag: a non-BCD nibble was accepted.

Function
REQ-014 Transfer SHALL occur on a rising edge where load_valid=1 and load_ready=1; the frame (load_data, dp_sel, blank_lz) SHALL go to a pending buffer and set pend_full.
REQ-015 load_ready SHALL equal ~pend_full from a register; while pend_full=1, load_valid SHALL be ignored.
REQ-016 Any accepted nibble >9 SHALL be stored as 0, and err SHALL set on the next edge until reset.
REQ-017 FSM states: IDLE (nothing displayed since reset) and SCAN.
REQ-018 IDLE: digit_en_n=4'b1111; when pend_full=1, copy pending to active, clear pend_full, set idx=0, clear prescaler, enter SCAN (one cycle after accept).
REQ-019 SCAN: prescaler counts 0..REFRESH_DIV-1 and wraps; tick is asserted when count=REFRESH_DIV-1.
REQ-020 On tick, idx SHALL advance 0->1->2->3->0.
REQ-021 Frame boundary = tick with idx=3; pending SHALL be copied to active only at a frame boundary with pend_full=1, clearing pend_full the same edge (no mid-frame tearing).
REQ-022 If a frame boundary copy and a load_valid coincide, the load SHALL NOT be accepted that cycle (ready is still low) and SHALL be accepted the next cycle.
REQ-023 Outputs SHALL be registered, one cycle after idx/active change: num_out=active digit[idx], dp_n=~dp[idx], digit_en_n bit idx low, others high.
REQ-024 Digit i (i=1..3) is blanked when blank_lz=1 and active digits i..3 are all 0; digit0 SHALL never be blanked.
REQ-025 Blanked slot: digit_en_n=4'b1111, num_out=0, dp_n=1; the slot duration SHALL be unchanged.
REQ-026 Prescaler width SHALL be ceil(log2(REFRESH_DIV)) bits; idx SHALL be 2 bits and wrap naturally.

Reset
REQ-027 On reset assertion, asynchronously: state=IDLE, idx=0, prescaler=0, pend_full=0, active/pending=0, load_ready=1, num_out=0, dp_n=1, digit_en_n=4'b1111, err=0.
REQ-028 Reset mid-scan or with pend_full=1 SHALL discard all frames; the first accept after deassertion SHALL follow REQ-018.

Verification (REFRESH_DIV=4)
REQ-029 Reset then idle 20 cycles -> digit_en_n=1111, load_ready=1, err=0 throughout.
REQ-030 Load 16'h1234, dp_sel=0100, blank_lz=0 -> a cycle later SCAN; slots of 4 cycles show (num_out,digit_en_n,dp_n) = (4,1110,1),(3,1101,1),(2,1011,0),(1,0111,1), repeating.
REQ-031 Load 16'h0050, blank_lz=1 -> digit0=0 enabled, digit1=5 enabled, digits 2,3 slots all-high; then 16'h0000 -> only digit0 shows 0.
REQ-032 While scanning 16'h1234, load 16'h5678 mid-frame -> load_ready=0 until the idx=3 tick; 5678 first appears on the digit0 slot following it; a second load_valid held high is accepted exactly one cycle after the copy.
REQ-033 Load 16'h12A4 -> err=1 next cycle and stays set; digit1 displays 0; err clears only on reset.
REQ-034 Assert reset during the idx=2 slot with pend_full=1 -> all outputs at reset values immediately, load_ready=1 after deassertion, old frames never reappear.
